pc_fetch_unit: RTL and testbench

//  Fetch-side consumer of the branch unit's redirect (branchPC, isBranchTaken). Holds the

---
 rtl/pc_fetch_unit.sv | 126 ++++++++++++
 tb/tb_pc_fetch_unit.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// Fetch-side PC and IF/OF pipeline latch. Applies branch redirects from EX and squashes the
// two wrong-path instructions. Also tracks taken-branch and squash counters and a sticky misalign flag.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h6800_0000,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             exValid,
    input  logic             isBranchTaken,
    input  logic [31:0]      branchPC,
    input  logic [31:0]      instrMem,
    output logic [31:0]      pc,
    output logic [31:0]      pcIF,
    output logic [31:0]      instrIF,
    output logic             validIF,
    output logic             flushOF,
    output logic             misalignErr,
    output logic [CNT_W-1:0] branchCnt,
    output logic [CNT_W-1:0] squashCnt
);

    typedef enum logic [1:0] {
        MODE_NORMAL   = 2'd0,
        MODE_STALL    = 2'd1,
        MODE_REDIRECT = 2'd2
    } mode_e;

    mode_e            mode;
    logic             redirect;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      pc_if_q, pc_if_d;
    logic [31:0]      instr_if_q, instr_if_d;
    logic             valid_if_q, valid_if_d;
    logic             valid_of_q, valid_of_d;
    logic             misalign_q, misalign_d;
    logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0] squash_cnt_q, squash_cnt_d;
    logic [CNT_W:0]   squash_sum;

    assign redirect = isBranchTaken & exValid;

    // Up to two valid wrong-path instructions die per redirect; one spare bit catches overflow.
    assign squash_sum = {1'b0, squash_cnt_q}
                      + {{CNT_W{1'b0}}, valid_if_q}
                      + {{CNT_W{1'b0}}, valid_of_q};

    always_comb begin
        mode         = MODE_NORMAL;
        pc_d         = pc_q;
        pc_if_d      = pc_if_q;
        instr_if_d   = instr_if_q;
        valid_if_d   = valid_if_q;
        valid_of_d   = valid_of_q;
        misalign_d   = misalign_q;
        branch_cnt_d = branch_cnt_q;
        squash_cnt_d = squash_cnt_q;

        if (redirect) begin
            mode = MODE_REDIRECT;
        end else if (stall) begin
            mode = MODE_STALL;
        end

        unique case (mode)
            MODE_REDIRECT: begin
                pc_d       = {branchPC[31:2], 2'b00};
                pc_if_d    = pc_q;
                instr_if_d = NOP_INSTR;
                valid_if_d = 1'b0;
                valid_of_d = 1'b0;
                if (branchPC[1:0] != 2'b00) begin
                    misalign_d = 1'b1;
                end
                if (branch_cnt_q != {CNT_W{1'b1}}) begin
                    branch_cnt_d = branch_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
                squash_cnt_d = squash_sum[CNT_W] ? {CNT_W{1'b1}} : squash_sum[CNT_W-1:0];
            end
            MODE_NORMAL: begin
                pc_d       = pc_q + 32'd4;
                pc_if_d    = pc_q;
                instr_if_d = instrMem;
                valid_if_d = 1'b1;
                valid_of_d = valid_if_q;
            end
            default: begin
                // Stall: everything holds.
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q         <= RESET_PC;
            pc_if_q      <= 32'h0000_0000;
            instr_if_q   <= NOP_INSTR;
            valid_if_q   <= 1'b0;
            valid_of_q   <= 1'b0;
            misalign_q   <= 1'b0;
            branch_cnt_q <= '0;
            squash_cnt_q <= '0;
        end else begin
            pc_q         <= pc_d;
            pc_if_q      <= pc_if_d;
            instr_if_q   <= instr_if_d;
            valid_if_q   <= valid_if_d;
            valid_of_q   <= valid_of_d;
            misalign_q   <= misalign_d;
            branch_cnt_q <= branch_cnt_d;
            squash_cnt_q <= squash_cnt_d;
        end
    end

    assign pc          = pc_q;
    assign pcIF        = pc_if_q;
    assign instrIF     = instr_if_q;
    assign validIF     = valid_if_q;
    assign flushOF     = redirect;
    assign misalignErr = misalign_q;
    assign branchCnt   = branch_cnt_q;
    assign squashCnt   = squash_cnt_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: a wide-counter instance and a 2-bit-counter instance share stimulus
// and are checked every cycle against a rule-level model, plus directed literal checks.
module tb_pc_fetch_unit;
    localparam logic [31:0] NOP = 32'h6800_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        ex_valid = 1'b0;
    logic        br_taken = 1'b0;
    logic [31:0] br_pc = 32'h0;
    logic [31:0] instr_mem;

    logic [31:0] pc_a, pcif_a, instr_a;
    logic        vif_a, flush_a, mis_a;
    logic [15:0] bc_a, sc_a;
    logic [31:0] pc_b, pcif_b, instr_b;
    logic        vif_b, flush_b, mis_b;
    logic [1:0]  bc_b, sc_b;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_of(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    assign instr_mem = mem_of(pc_a);

    pc_fetch_unit dut_a (
        .clk(clk), .reset(rst), .stall(stall), .exValid(ex_valid), .isBranchTaken(br_taken),
        .branchPC(br_pc), .instrMem(instr_mem), .pc(pc_a), .pcIF(pcif_a), .instrIF(instr_a),
        .validIF(vif_a), .flushOF(flush_a), .misalignErr(mis_a), .branchCnt(bc_a), .squashCnt(sc_a)
    );

    pc_fetch_unit #(.CNT_W(2)) dut_b (
        .clk(clk), .reset(rst), .stall(stall), .exValid(ex_valid), .isBranchTaken(br_taken),
        .branchPC(br_pc), .instrMem(instr_mem), .pc(pc_b), .pcIF(pcif_b), .instrIF(instr_b),
        .validIF(vif_b), .flushOF(flush_b), .misalignErr(mis_b), .branchCnt(bc_b), .squashCnt(sc_b)
    );

    // Rule-level model: unbounded event counts, saturation applied only when comparing.
    logic [31:0] m_pc = 32'h0, m_pcif = 32'h0, m_instr = NOP;
    logic        m_vif = 1'b0, m_vof = 1'b0, m_mis = 1'b0;
    int          m_br = 0, m_sq = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pc <= 32'h0; m_pcif <= 32'h0; m_instr <= NOP;
            m_vif <= 1'b0; m_vof <= 1'b0; m_mis <= 1'b0; m_br <= 0; m_sq <= 0;
        end else if (br_taken && ex_valid) begin
            m_pc    <= br_pc & 32'hFFFF_FFFC;
            m_pcif  <= m_pc;
            m_instr <= NOP;
            m_vif   <= 1'b0;
            m_vof   <= 1'b0;
            m_mis   <= m_mis | (br_pc[1:0] != 2'b00);
            m_br    <= m_br + 1;
            m_sq    <= m_sq + int'(m_vif) + int'(m_vof);
        end else if (!stall) begin
            m_pc    <= m_pc + 32'd4;
            m_pcif  <= m_pc;
            m_instr <= mem_of(m_pc);
            m_vif   <= 1'b1;
            m_vof   <= m_vif;
        end
    end

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always begin
        @(negedge clk);
        #2;
        if (cmp_en) begin
            check("pc", pc_a, m_pc);
            check("pcIF", pcif_a, m_pcif);
            check("instrIF", instr_a, m_instr);
            check("validIF", {31'b0, vif_a}, {31'b0, m_vif});
            check("flushOF", {31'b0, flush_a}, {31'b0, br_taken & ex_valid});
            check("misalignErr", {31'b0, mis_a}, {31'b0, m_mis});
            check("branchCnt", {16'b0, bc_a}, 32'(sat(m_br, 65535)));
            check("squashCnt", {16'b0, sc_a}, 32'(sat(m_sq, 65535)));
            check("pc_s", pc_b, m_pc);
            check("validIF_s", {31'b0, vif_b}, {31'b0, m_vif});
            check("flushOF_s", {31'b0, flush_b}, {31'b0, br_taken & ex_valid});
            check("branchCnt_s", {30'b0, bc_b}, 32'(sat(m_br, 3)));
            check("squashCnt_s", {30'b0, sc_b}, 32'(sat(m_sq, 3)));
        end
    end

    task automatic step(input logic st, input logic tk, input logic ev, input logic [31:0] bp);
        stall = st; br_taken = tk; ex_valid = ev; br_pc = bp;
        @(negedge clk);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_rst_pc"}, pc_a, 32'h0);
        check({tag, "_rst_pcIF"}, pcif_a, 32'h0);
        check({tag, "_rst_instrIF"}, instr_a, NOP);
        check({tag, "_rst_validIF"}, {31'b0, vif_a}, 32'h0);
        check({tag, "_rst_mis"}, {31'b0, mis_a}, 32'h0);
        check({tag, "_rst_bc"}, {16'b0, bc_a}, 32'h0);
        check({tag, "_rst_sc"}, {16'b0, sc_a}, 32'h0);
        check({tag, "_rst_pc_s"}, pc_b, 32'h0);
        check({tag, "_rst_bc_s"}, {30'b0, bc_b}, 32'h0);
        check({tag, "_rst_sc_s"}, {30'b0, sc_b}, 32'h0);
    endtask

    initial begin
        #1 rst = 1'b1;
        #1 check_reset("init");
        @(negedge clk);
        rst = 1'b0;
        cmp_en = 1'b1;

        // Reset release, free-running fetch
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("t1_pc", pc_a, 32'h4);
        check("t1_pcIF", pcif_a, 32'h0);
        check("t1_validIF", {31'b0, vif_a}, 32'h1);
        check("t1_instrIF", instr_a, 32'h0000_FFFF);
        repeat (3) step(1'b0, 1'b0, 1'b0, 32'h0);
        check("t1_pc4", pc_a, 32'h10);

        // Stall for three cycles at 0x10
        repeat (3) step(1'b1, 1'b0, 1'b0, 32'h0);
        check("t2_pc", pc_a, 32'h10);
        check("t2_pcIF", pcif_a, 32'hC);
        check("t2_instrIF", instr_a, 32'h000C_FFF3);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("t2_resume", pc_a, 32'h14);
        repeat (3) step(1'b0, 1'b0, 1'b0, 32'h0);
        check("t3_pre_pc", pc_a, 32'h20);

        // Redirect to 0x100
        stall = 1'b0; br_taken = 1'b1; ex_valid = 1'b1; br_pc = 32'h100;
        #1 check("t3_flush", {31'b0, flush_a}, 32'h1);
        @(negedge clk);
        check("t3_pc", pc_a, 32'h100);
        check("t3_validIF", {31'b0, vif_a}, 32'h0);
        check("t3_instrIF", instr_a, 32'h6800_0000);
        check("t3_pcIF", pcif_a, 32'h20);
        check("t3_bc", {16'b0, bc_a}, 32'd1);
        check("t3_sc", {16'b0, sc_a}, 32'd2);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("t3_tgt_pcIF", pcif_a, 32'h100);
        check("t3_tgt_valid", {31'b0, vif_a}, 32'h1);
        check("t3_tgt_instr", instr_a, 32'h0100_FEFF);

        // Redirect together with stall, then taken branch from a bubble
        step(1'b1, 1'b1, 1'b1, 32'h40);
        check("t4_pc", pc_a, 32'h40);
        check("t4_sc", {16'b0, sc_a}, 32'd3);
        stall = 1'b0; br_taken = 1'b1; ex_valid = 1'b0; br_pc = 32'h80;
        #1 check("t4_noflush", {31'b0, flush_a}, 32'h0);
        @(negedge clk);
        check("t4_bubble_pc", pc_a, 32'h44);
        check("t4_bc", {16'b0, bc_a}, 32'd2);

        // Misaligned target, then PC wrap
        step(1'b0, 1'b1, 1'b1, 32'h203);
        check("t5_pc", pc_a, 32'h200);
        check("t5_mis", {31'b0, mis_a}, 32'h1);
        repeat (2) step(1'b0, 1'b0, 1'b0, 32'h0);
        check("t5_mis_sticky", {31'b0, mis_a}, 32'h1);
        check("t5_pc2", pc_a, 32'h208);
        step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
        check("t5_pc_top", pc_a, 32'hFFFF_FFFC);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("t5_wrap", pc_a, 32'h0);
        check("t5_wrap_pcIF", pcif_a, 32'hFFFF_FFFC);
        check("t5_bc", {16'b0, bc_a}, 32'd4);
        check("t5_sc", {16'b0, sc_a}, 32'd6);
        check("t5_bc_sat", {30'b0, bc_b}, 32'd3);
        check("t5_sc_sat", {30'b0, sc_b}, 32'd3);

        // Async reset one cycle after a redirect, saturated narrow counters
        step(1'b0, 1'b1, 1'b1, 32'h300);
        check("t6_pc", pc_a, 32'h300);
        check("t6_bc_sat", {30'b0, bc_b}, 32'd3);
        stall = 1'b0; br_taken = 1'b0; ex_valid = 1'b0; br_pc = 32'h0;
        #4 rst = 1'b1;
        #1 check_reset("async");
        @(negedge clk);
        rst = 1'b0;
        repeat (2) step(1'b0, 1'b0, 1'b0, 32'h0);
        check("t6_restart_pc", pc_a, 32'h8);
        check("t6_restart_pcIF", pcif_a, 32'h4);

        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
